// File: rtl/iagu_layer_sequencer_pkg.sv
// Shared NPU parameters for the layer sequencer: mode encodings, completion codes, FSM states.
package iagu_layer_sequencer_pkg;

    localparam logic [3:0] ModeNone      = 4'd0;
    localparam logic [3:0] ModeConv      = 4'd1;
    localparam logic [3:0] ModeFc        = 4'd2;
    localparam logic [3:0] ModeAdd       = 4'd3;
    localparam logic [3:0] ModePool      = 4'd4;
    localparam logic [3:0] ModeAcc       = 4'd5;
    localparam logic [3:0] ModeDepthConv = 4'd6;

    localparam logic [1:0] ErrOk      = 2'd0;
    localparam logic [1:0] ErrIllegal = 2'd1;
    localparam logic [1:0] ErrTimeout = 2'd2;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StRun,
        StSortStart,
        StSortRun,
        StDone
    } seq_state_e;

    function automatic logic is_legal_mode(input logic [3:0] m);
        return (m >= ModeConv) && (m <= ModeDepthConv);
    endfunction

    // Modes whose main pass ends after part_num feature_end pulses.
    function automatic logic is_count_mode(input logic [3:0] m);
        return (m == ModeConv) || (m == ModeFc) || (m == ModeDepthConv);
    endfunction

endpackage

// File: rtl/iagu_watchdog.sv
// Loadable saturating watchdog; expire flags the cycle whose increment reaches all-ones.
module iagu_watchdog #(
    parameter int unsigned Width = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam logic [Width-1:0] Last = {{(Width-1){1'b1}}, 1'b0};

    logic [Width-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // A clear in the same cycle (awaited pulse) always wins over expiry.
    assign expire = en && !clr && (cnt_q >= Last);

endmodule

// File: rtl/iagu_layer_sequencer.sv
// Layer sequencer: accepts a decoded layer instruction, drives the address generator
// through main and optional sort passes, and returns a tagged completion record.
module iagu_layer_sequencer
    import iagu_layer_sequencer_pkg::*;
#(
    parameter int unsigned TMO_W = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       instr_valid,
    output logic       instr_ready,
    input  logic [3:0] instr_mode,
    input  logic [4:0] instr_part_num,
    input  logic       instr_sort_en,
    input  logic [7:0] instr_tag,
    input  logic       feature_end,
    input  logic       layer_done,
    input  logic       sort_done,
    input  logic       abort,
    output logic       start_calculate,
    output logic [3:0] mode,
    output logic       sort_en,
    output logic       busy,
    output logic       done_valid,
    input  logic       done_ready,
    output logic [7:0] done_tag,
    output logic [1:0] done_err
);

    seq_state_e state_q, state_d;
    logic [3:0] mode_q;
    logic [4:0] part_q;
    logic       sort_q;
    logic [7:0] tag_q;
    logic [4:0] fe_cnt_q, fe_cnt_d;
    logic [7:0] done_tag_q, done_tag_d;
    logic [1:0] done_err_q, done_err_d;
    logic       accept, wd_clr, wd_en, wd_expire, finish;
    logic [4:0] part_tgt, fe_next;

    assign part_tgt = (part_q == 5'd0) ? 5'd1 : part_q;
    assign fe_next  = fe_cnt_q + 5'd1;

    iagu_watchdog #(
        .Width(TMO_W)
    ) u_watchdog (
        .clk   (clk),
        .rst   (rst),
        .clr   (wd_clr),
        .en    (wd_en),
        .expire(wd_expire)
    );

    always_comb begin
        state_d    = state_q;
        fe_cnt_d   = fe_cnt_q;
        done_tag_d = done_tag_q;
        done_err_d = done_err_q;
        accept     = 1'b0;
        wd_clr     = 1'b0;
        wd_en      = 1'b0;
        finish     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (instr_valid) begin
                    accept = 1'b1;
                    if (is_legal_mode(instr_mode)) begin
                        state_d = StStart;
                    end else begin
                        state_d    = StDone;
                        done_tag_d = instr_tag;
                        done_err_d = ErrIllegal;
                    end
                end
            end
            StStart: begin
                wd_clr   = 1'b1;
                fe_cnt_d = 5'd0;
                state_d  = StRun;
            end
            StRun: begin
                wd_en = 1'b1;
                if (is_count_mode(mode_q)) begin
                    if (feature_end) begin
                        wd_clr   = 1'b1;
                        fe_cnt_d = fe_next;
                        finish   = (fe_next == part_tgt);
                    end
                end else if (layer_done) begin
                    wd_clr = 1'b1;
                    finish = 1'b1;
                end
                if (finish) begin
                    state_d = sort_q ? StSortStart : StDone;
                    if (!sort_q) begin
                        done_tag_d = tag_q;
                        done_err_d = ErrOk;
                    end
                end else if (wd_expire) begin
                    state_d    = StDone;
                    done_tag_d = tag_q;
                    done_err_d = ErrTimeout;
                end
            end
            StSortStart: begin
                wd_clr  = 1'b1;
                state_d = StSortRun;
            end
            StSortRun: begin
                wd_en = 1'b1;
                if (sort_done) begin
                    wd_clr     = 1'b1;
                    state_d    = StDone;
                    done_tag_d = tag_q;
                    done_err_d = ErrOk;
                end else if (wd_expire) begin
                    state_d    = StDone;
                    done_tag_d = tag_q;
                    done_err_d = ErrTimeout;
                end
            end
            StDone: begin
                if (done_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        // Abort drops the layer silently and overrides any coincident pulse or timeout.
        if (abort && (state_q != StIdle)) state_d = StIdle;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            mode_q     <= ModeNone;
            part_q     <= 5'd0;
            sort_q     <= 1'b0;
            tag_q      <= 8'd0;
            fe_cnt_q   <= 5'd0;
            done_tag_q <= 8'd0;
            done_err_q <= ErrOk;
        end else begin
            state_q    <= state_d;
            fe_cnt_q   <= fe_cnt_d;
            done_tag_q <= done_tag_d;
            done_err_q <= done_err_d;
            if (accept) begin
                mode_q <= instr_mode;
                part_q <= instr_part_num;
                sort_q <= instr_sort_en;
                tag_q  <= instr_tag;
            end
        end
    end

    assign instr_ready     = (state_q == StIdle);
    assign busy            = (state_q != StIdle);
    assign start_calculate = (state_q == StStart) || (state_q == StSortStart);
    assign mode            = ((state_q == StStart) || (state_q == StRun)) ? mode_q : ModeNone;
    assign sort_en         = (state_q == StSortStart) || (state_q == StSortRun);
    assign done_valid      = (state_q == StDone);
    assign done_tag        = done_tag_q;
    assign done_err        = done_err_q;

endmodule

// File: tb/tb_iagu_layer_sequencer.sv
// Directed bench for iagu_layer_sequencer with a completion-record scoreboard.
module tb_iagu_layer_sequencer;
    import iagu_layer_sequencer_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       instr_valid, instr_ready, instr_sort_en;
    logic [3:0] instr_mode;
    logic [4:0] instr_part_num;
    logic [7:0] instr_tag;
    logic       feature_end, layer_done, sort_done, abort;
    logic       start_calculate, sort_en, busy, done_valid, done_ready;
    logic [3:0] mode;
    logic [7:0] done_tag;
    logic [1:0] done_err;

    typedef struct packed {
        logic [7:0] tag;
        logic [1:0] err;
    } rec_t;

    rec_t       exp_q[$];
    logic [4:0] starts_q[$];
    int         total = 0;
    int         bad = 0;

    always #5 clk = ~clk;

    iagu_layer_sequencer #(
        .TMO_W(4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_mode     (instr_mode),
        .instr_part_num (instr_part_num),
        .instr_sort_en  (instr_sort_en),
        .instr_tag      (instr_tag),
        .feature_end    (feature_end),
        .layer_done     (layer_done),
        .sort_done      (sort_done),
        .abort          (abort),
        .start_calculate(start_calculate),
        .mode           (mode),
        .sort_en        (sort_en),
        .busy           (busy),
        .done_valid     (done_valid),
        .done_ready     (done_ready),
        .done_tag       (done_tag),
        .done_err       (done_err)
    );

    // Record every start pulse as {mode, sort_en}.
    always @(negedge clk) begin
        if (rst && start_calculate) starts_q.push_back({mode, sort_en});
    end

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] m, input logic [4:0] p, input logic s,
                         input logic [7:0] t);
        int n = 0;
        while (!instr_ready && n < 20) begin
            step();
            n++;
        end
        chk("issue_ready", int'(instr_ready), 1);
        starts_q.delete();
        instr_valid    = 1'b1;
        instr_mode     = m;
        instr_part_num = p;
        instr_sort_en  = s;
        instr_tag      = t;
        step();
        instr_valid = 1'b0;
    endtask

    task automatic pulse_fe();
        feature_end = 1'b1;
        step();
        feature_end = 1'b0;
    endtask

    task automatic expect_done(input string tag, input int max_cycles);
        int   n = 0;
        rec_t r;
        while (!done_valid && n < max_cycles) begin
            step();
            n++;
        end
        chk({tag, "_done_seen"}, int'(done_valid), 1);
        if (done_valid && exp_q.size() > 0) begin
            r = exp_q.pop_front();
            chk({tag, "_tag"}, int'(done_tag), int'(r.tag));
            chk({tag, "_err"}, int'(done_err), int'(r.err));
            chk({tag, "_mode_idle"}, int'(mode), 0);
        end
        done_ready = 1'b1;
        step();
        done_ready = 1'b0;
        chk({tag, "_back_idle"}, int'(instr_ready), 1);
    endtask

    initial begin
        int n;
        rst = 1'b0;
        instr_valid = 1'b0; instr_mode = 4'd0; instr_part_num = 5'd0;
        instr_sort_en = 1'b0; instr_tag = 8'd0;
        feature_end = 1'b0; layer_done = 1'b0; sort_done = 1'b0; abort = 1'b0;
        done_ready = 1'b0;
        #2;
        chk("rst_ready", int'(instr_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_dvalid", int'(done_valid), 0);
        chk("rst_start", int'(start_calculate), 0);
        step();
        rst = 1'b1;
        step();

        // CONV, three parts, completion held until done_ready.
        issue(ModeConv, 5'd3, 1'b0, 8'hA5);
        exp_q.push_back('{tag: 8'hA5, err: ErrOk});
        chk("conv_start", int'(start_calculate), 1);
        chk("conv_start_mode", int'(mode), 1);
        chk("conv_start_sort", int'(sort_en), 0);
        step();
        chk("conv_run_pulse_once", int'(start_calculate), 0);
        chk("conv_run_mode_held", int'(mode), 1);
        pulse_fe();
        pulse_fe();
        chk("conv_not_done_early", int'(done_valid), 0);
        pulse_fe();
        chk("conv_done_now", int'(done_valid), 1);
        step();
        step();
        chk("conv_hold_valid", int'(done_valid), 1);
        chk("conv_hold_tag", int'(done_tag), 'hA5);
        chk("conv_starts", starts_q.size(), 1);
        expect_done("conv", 4);

        // POOL with sort pass; feature_end must be ignored.
        issue(ModePool, 5'd1, 1'b1, 8'h3C);
        exp_q.push_back('{tag: 8'h3C, err: ErrOk});
        step();
        pulse_fe();
        chk("pool_fe_ignored", int'(done_valid | start_calculate), 0);
        layer_done = 1'b1;
        step();
        layer_done = 1'b0;
        chk("pool_sort_start", int'(start_calculate), 1);
        chk("pool_sort_mode", int'(mode), 0);
        chk("pool_sort_en", int'(sort_en), 1);
        step();
        chk("pool_sortrun_en", int'(sort_en), 1);
        sort_done = 1'b1;
        step();
        sort_done = 1'b0;
        chk("pool_starts", starts_q.size(), 2);
        if (starts_q.size() == 2) begin
            chk("pool_start0", int'(starts_q[0]), 8);
            chk("pool_start1", int'(starts_q[1]), 1);
        end
        expect_done("pool", 2);

        // Illegal mode: completion next cycle with no start pulse.
        issue(4'd9, 5'd1, 1'b0, 8'h77);
        exp_q.push_back('{tag: 8'h77, err: ErrIllegal});
        chk("illegal_done_next", int'(done_valid), 1);
        chk("illegal_no_start", starts_q.size(), 0);
        expect_done("illegal", 1);

        // FC with no feature_end: timeout after 15 RUN cycles.
        issue(ModeFc, 5'd2, 1'b0, 8'h11);
        exp_q.push_back('{tag: 8'h11, err: ErrTimeout});
        n = 0;
        while (!done_valid && n < 40) begin
            step();
            n++;
        end
        chk("tmo_run_cycles", n - 1, 15);
        expect_done("tmo", 1);

        // Awaited pulse coincident with watchdog expiry wins.
        issue(ModeFc, 5'd1, 1'b0, 8'h66);
        exp_q.push_back('{tag: 8'h66, err: ErrOk});
        for (int i = 0; i < 15; i++) step();
        chk("race_still_running", int'(busy & ~done_valid), 1);
        pulse_fe();
        expect_done("race", 1);

        // part_num 0 behaves as 1.
        issue(ModeDepthConv, 5'd0, 1'b0, 8'h55);
        exp_q.push_back('{tag: 8'h55, err: ErrOk});
        step();
        pulse_fe();
        expect_done("part0", 1);

        // Abort coincident with the final feature_end.
        issue(ModeConv, 5'd2, 1'b0, 8'h22);
        step();
        pulse_fe();
        feature_end = 1'b1;
        abort = 1'b1;
        step();
        feature_end = 1'b0;
        abort = 1'b0;
        chk("abort_idle", int'(instr_ready), 1);
        n = 0;
        for (int i = 0; i < 5; i++) begin
            if (done_valid) n++;
            step();
        end
        chk("abort_no_record", n, 0);

        // Asynchronous reset mid-RUN.
        issue(ModeConv, 5'd3, 1'b0, 8'h44);
        step();
        pulse_fe();
        #2;
        rst = 1'b0;
        #1;
        chk("arst_busy", int'(busy), 0);
        chk("arst_ready", int'(instr_ready), 1);
        chk("arst_mode", int'(mode), 0);
        chk("arst_dtag", int'(done_tag), 0);
        chk("arst_derr", int'(done_err), 0);
        chk("arst_dvalid", int'(done_valid), 0);
        step();
        rst = 1'b1;
        step();
        chk("arst_release_ready", int'(instr_ready), 1);
        chk("arst_no_record", int'(done_valid), 0);

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/iagu_layer_sequencer.md
IAGU_LAYER_SEQUENCER -- requirements
Module: iagu_layer_sequencer

Interface
REQ-001 SHALL have parameter TMO_W, default 20, watchdog counter width.
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous active-low reset.
REQ-004 SHALL have port instr_valid  input  1  decoded layer instruction present.
REQ-005 SHALL have port instr_ready  output  1  sequencer accepts instruction.
REQ-006 SHALL have port instr_mode  input  4  1 CONV, 2 FC, 3 ADD, 4 POOL, 5 ACC, 6 DEPTHCONV.
REQ-007 SHALL have port instr_part_num  input  5  feature_end pulses expected per layer.
REQ-008 SHALL have port instr_sort_en  input  1  run a sort pass after the main pass.
REQ-009 SHALL have port instr_tag  input  8  layer identifier, echoed on completion.
REQ-010 SHALL have port feature_end  input  1  one-cycle pulse from address generator.
REQ-011 SHALL have port layer_done  input  1  one-cycle pulse, ADD/POOL/ACC pass complete.
REQ-012 SHALL have port sort_done  input  1  one-cycle pulse, sort pass complete.
REQ-013 SHALL have port abort  input  1  synchronous cancel.
REQ-014 SHALL have port start_calculate  output  1  one-cycle start pulse to address generator.
REQ-015 SHALL have port mode  output  4  held mode to address generator.
REQ-016 SHALL have port sort_en  output  1  held sort enable to address generator.
REQ-017 SHALL have port busy  output  1  high in every state except IDLE.
REQ-018 SHALL have port done_valid  output  1  completion record valid.
REQ-019 SHALL have port done_ready  input  1  completion record consumed.
REQ-020 SHALL have port done_tag  output  8  tag of completed layer.
REQ-021 SHALL have port done_err  output  2  0 ok, 1 illegal mode, 2 timeout.

Function
REQ-022 SHALL use states IDLE, START, RUN, SORT_START, SORT_RUN, DONE.
REQ-023 SHALL drive instr_ready=1 only in IDLE; accept on instr_valid&&instr_ready and latch mode, part_num, sort_en, tag.
REQ-024 SHALL, on acceptance of a legal mode, go to START; on mode 0 or 7..15, go directly to DONE with done_err=1 and no start pulse.
REQ-025 SHALL in START assert start_calculate for exactly one cycle with mode=latched mode and sort_en=0, then go to RUN.
REQ-026 SHALL in RUN for modes 1,2,6 count feature_end pulses (5-bit) and leave RUN in the cycle the count reaches part_num; part_num 0 is treated as 1.
REQ-027 SHALL in RUN for modes 3,4,5 leave RUN on layer_done; feature_end is ignored for these modes.
REQ-028 SHALL leave RUN to SORT_START if latched sort_en=1, else to DONE with done_err=0.
REQ-029 SHALL in SORT_START assert start_calculate one cycle with mode=0 and sort_en=1, then go to SORT_RUN; mode=0 guarantees no main generator restarts.
REQ-030 SHALL leave SORT_RUN on sort_done to DONE with done_err=0.
REQ-031 SHALL ignore feature_end, layer_done, sort_done outside the state that waits for them.
REQ-032 SHALL keep a TMO_W-bit watchdog, cleared on entry to RUN/SORT_RUN and on every awaited pulse; on reaching all-ones go to DONE with done_err=2.
REQ-033 SHALL hold done_valid, done_tag, done_err stable in DONE until done_ready; return to IDLE the cycle after done_valid&&done_ready.
REQ-034 SHALL hold mode and sort_en from START until DONE exit; drive mode=0, sort_en=0 in IDLE and DONE.
REQ-035 SHALL, on abort in any non-IDLE state, go to IDLE next cycle without a completion record; abort beats any coincident pulse or timeout.
REQ-036 SHALL give a completion pulse priority over a coincident watchdog expiry.

Reset
REQ-037 SHALL on rst low force IDLE, counters 0, start_calculate 0, mode 0, sort_en 0, busy 0, done_valid 0, done_tag 0, done_err 0, instr_ready 1.
REQ-038 SHALL discard any in-flight layer on reset mid-operation; no completion record is produced.

Structure
REQ-039 SHALL take mode encodings and done_err codes from the shared NPU parameter package, not local constants.
REQ-040 SHALL be one module with a single sub-module iagu_watchdog (loadable saturating counter with expire flag).

Verification
REQ-041 SHALL cover CONV, part_num=3, 3 feature_end pulses -> one start pulse, done_valid with tag echoed, done_err=0.
REQ-042 SHALL cover POOL, sort_en=1, layer_done then sort_done -> two start pulses, second with mode=0, sort_en=1; then done.
REQ-043 SHALL cover mode=9 -> no start pulse, done_valid next cycle, done_err=1.
REQ-044 SHALL cover TMO_W=4, FC with no feature_end -> done_err=2 after 15 RUN cycles.
REQ-045 SHALL cover abort coincident with final feature_end -> IDLE, no done_valid.
REQ-046 SHALL cover rst low mid-RUN -> all outputs at reset values asynchronously, instr_ready=1 after release.
